// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and baud divisor helper.
package uart_pkg;

    typedef enum int unsigned {
        PAR_NONE = 0,
        PAR_ODD  = 1,
        PAR_EVEN = 2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Nearest-integer clocks per bit.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// Loadable down-counter that parks at zero; o_zero marks a bit-timing tick.
module uart_baud_ctr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised rx, mid-bit sampling, parity/stop
// checking, single-entry output register with valid/ready handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 66_000_000,
    parameter int unsigned BAUD        = 9_600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV) + 1;
    localparam parity_e     PAR_MODE = parity_e'(PARITY);

    localparam logic [2:0] S_IDLE      = RX_IDLE;
    localparam logic [2:0] S_START     = RX_START;
    localparam logic [2:0] S_DATA      = RX_DATA;
    localparam logic [2:0] S_PARITY    = RX_PARITY;
    localparam logic [2:0] S_STOP      = RX_STOP;
    localparam logic [2:0] S_WAIT_IDLE = RX_WAIT_IDLE;

    if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("uart_rx_param: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [2:0]             r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [3:0]             r_bit_cnt;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_commit;

    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_load;
    logic [CW-1:0]          w_load_val;
    logic                   w_last_data;
    logic                   w_last_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_fall      = r_rx_prev && !w_rx_s;
    assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
    assign busy        = (r_state != S_IDLE);

    // First load lands on mid start bit; every later load spaces samples one bit apart.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = CW'(DIV - 1);
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_load     = 1'b1;
                    w_load_val = CW'(HALF - 1);
                end
            end
            S_START:          w_load = w_tick && !w_rx_s;
            S_DATA, S_PARITY: w_load = w_tick;
            S_STOP:           w_load = w_tick && !w_last_stop;
            default:          w_load = 1'b0;
        endcase
    end

    uart_baud_ctr #(
        .WIDTH(CW)
    ) u_baud_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rx_prev <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_commit  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) r_state <= S_START;
                end
                S_START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_perr    <= 1'b0;
                            r_ferr    <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (w_last_data) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_perr  <= (((^r_shift) ^ w_rx_s) != (PAR_MODE == PAR_ODD));
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_ferr <= r_ferr | !w_rx_s;
                        if (w_last_stop) begin
                            r_commit <= 1'b1;
                            r_state  <= w_rx_s ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A commit wins over a same-cycle accept: the old frame is consumed, the new one loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_commit) begin
            data       <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr;
            overrun    <= data_valid && !data_ready;
            data_valid <= 1'b1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at 16 clks/bit.
module tb_uart_rx_param;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1, rx2;
    logic rdy0, rdy1, rdy2;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bz0, bz1, bz2;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data(d0), .data_valid(dv0), .data_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0));

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(d1), .data_valid(dv1), .data_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1));

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .data(d2), .data_valid(dv2), .data_ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(bz2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int inst, input logic b);
        case (inst)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    // pbit < 0 means no parity bit on the line; the line is left at stopv afterwards.
    task automatic send(input int inst, input logic [8:0] payload, input int nbits,
                        input int pbit, input logic stopv, input int nstop);
        set_rx(inst, 1'b0);
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(inst, payload[i]);
            repeat (DIV) @(negedge clk);
        end
        if (pbit >= 0) begin
            set_rx(inst, pbit[0]);
            repeat (DIV) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(inst, stopv);
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic accept(input int inst, input string tag);
        case (inst)
            0:       rdy0 = 1'b1;
            1:       rdy1 = 1'b1;
            default: rdy2 = 1'b1;
        endcase
        @(negedge clk);
        case (inst)
            0:       chk(tag, dv0, 1'b0);
            1:       chk(tag, dv1, 1'b0);
            default: chk(tag, dv2, 1'b0);
        endcase
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dv0", dv0, 1'b0);
        chk("rst_d0", d0, 8'h00);
        chk("rst_flags0", {pe0, fe0, ov0, bz0}, 4'b0000);
        chk("rst_dv2", dv2, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0xA5: 2 sync flops + 1 edge-detect cycle + 9.5*16 + 1
        fork
            send(0, 9'h0A5, 8, -1, 1'b1, 1);
            begin
                lat = 0;
                while (dv0 !== 1'b1 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk("latency_a5", lat, 156);
        chk("data_a5", d0, 8'hA5);
        chk("flags_a5", {pe0, fe0, ov0}, 3'b000);
        chk("busy_after_a5", bz0, 1'b0);
        accept(0, "accept_a5");

        // False start: 3-clk low pulse
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_start", bz0, 1'b1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_end", bz0, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        chk("glitch_no_valid", dv0, 1'b0);

        // Break: zero payload, stop bit 0, line held low
        send(0, 9'h000, 8, -1, 1'b0, 1);
        chk("break_valid", dv0, 1'b1);
        chk("break_data", d0, 8'h00);
        chk("break_ferr", fe0, 1'b1);
        chk("break_perr", pe0, 1'b0);
        chk("break_wait_busy", bz0, 1'b1);
        accept(0, "break_accept");
        repeat (3 * DIV) @(negedge clk);
        chk("break_no_second", dv0, 1'b0);
        chk("break_still_busy", bz0, 1'b1);
        rx0 = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("break_released", {dv0, bz0}, 2'b00);
        send(0, 9'h03C, 8, -1, 1'b1, 1);
        chk("after_break_data", d0, 8'h3C);
        chk("after_break_flags", {dv0, fe0, ov0}, 3'b100);
        accept(0, "after_break_accept");

        // Overrun: two frames with data_ready low
        send(0, 9'h011, 8, -1, 1'b1, 1);
        chk("ovr_first_data", d0, 8'h11);
        chk("ovr_first_flag", {dv0, ov0}, 2'b10);
        send(0, 9'h022, 8, -1, 1'b1, 1);
        chk("ovr_second_data", d0, 8'h22);
        chk("ovr_second_flag", {dv0, ov0}, 2'b11);
        accept(0, "ovr_accept");

        // Even parity: 0x03 with parity 1 is wrong, with 0 is right
        send(1, 9'h003, 8, 1, 1'b1, 1);
        chk("even_bad_data", d1, 8'h03);
        chk("even_bad_flags", {dv1, pe1, fe1}, 3'b110);
        accept(1, "even_bad_accept");
        send(1, 9'h003, 8, 0, 1'b1, 1);
        chk("even_good_flags", {dv1, pe1, fe1, ov1}, 4'b1000);
        accept(1, "even_good_accept");

        // 7 data bits, odd parity, 2 stop bits
        send(2, 9'h055, 7, 1, 1'b1, 2);
        chk("odd_55_data", d2, 7'h55);
        chk("odd_55_flags", {dv2, pe2, fe2, ov2}, 4'b1000);

        // Second frame aborted by reset midway through data bit 3
        rx2 = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx2 = (i == 1);
            repeat (DIV) @(negedge clk);
        end
        rx2 = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        rx2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_outputs", {dv2, pe2, fe2, ov2, bz2}, 5'b00000);
        chk("midrst_data", d2, 7'h00);
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        chk("midrst_idle", {dv2, bz2}, 2'b00);

        send(2, 9'h02A, 7, 0, 1'b1, 2);
        chk("post_rst_data", d2, 7'h2A);
        chk("post_rst_flags", {dv2, pe2, fe2, ov2}, 4'b1000);
        accept(2, "post_rst_accept");
        send(2, 9'h02A, 7, 1, 1'b1, 2);
        chk("odd_bad_flags", {dv2, pe2, fe2, ov2}, 4'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
